poly1305_block_formatter: RTL
=============================

// Module: poly1305_block_formatter
// PURPOSE
//  Upstream feeder for the ChaCha20-Poly1305 core's MAC path. Accepts AAD and ciphertext as
//  16-byte beats and zero-pads the last partial beat of each section. Emits RFC 8439 Poly1305
//  message blocks as 130-bit values with bit 128 set (block + 2^128), then one final length block.
//  Sits between the cipher datapath and the accumulate-multiply-reduce stage.
// PARAMETERS
//  LEN_W  64  width of the AAD and CT byte-length counters; also the length-block field width (<=64)
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  reset_n    in   1    asynchronous active-low reset
//  start      in   1    pulse: begin a message; sampled only in IDLE
//  has_aad    in   1    sampled with start: AAD section present
//  has_ct     in   1    sampled with start: CT section present
//  in_valid   in   1    input beat valid
//  in_ready   out  1    input beat accepted when in_valid & in_ready
//  in_data    in   128  beat bytes, byte 0 at [7:0] (little-endian)
//  in_bytes   in   5    valid bytes in beat, 1..16
//  in_last    in   1    last beat of current section
//  out_valid  out  1    output block valid
//  out_ready  in   1    downstream accepts when out_valid & out_ready
//  out_block  out  130  Poly1305 block value; [128]=1, [129]=0
//  out_is_len out  1    qualifies out_block as the final length block
//  busy       out  1    high in every state except IDLE
//  done       out  1    1-cycle pulse when the length block is accepted
//  err        out  1    sticky protocol error, cleared by start
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, out_valid=0, out_block=0, out_is_len=0, busy=0, done=0, err=0;
//   both length counters = 0.
//  FSM states: IDLE -> AAD -> CT -> LEN -> IDLE.
//   - start in IDLE: clear counters and err.
//   - Goes to AAD if has_aad, else CT if has_ct, else LEN.
//   - AAD --(accepted beat with in_last)--> CT if has_ct, else LEN.
//   - CT --(accepted beat with in_last)--> LEN.
//   - LEN --(length block accepted)--> IDLE, with done pulsed.
//  start outside IDLE: ignored; no effect on state or err.
//  in_ready = (state==AAD | state==CT) & (!out_valid | out_ready). Combinational; one-entry output register.
//  Accepted beat:
//   - bytes k >= in_bytes forced to 0 (zero pad);
//   - out_block <= {1'b0, 1'b1, masked_data};
//   - out_valid <= 1 on the next edge (latency 1 cycle);
//   - the section's counter += in_bytes.
//  A full beat still emits a block; an empty section emits no block.
//  Output slot:
//   - out_valid holds and out_block/out_is_len stay stable until accepted;
//   - accept and refill in the same cycle is legal (full throughput, 1 block/clk).
//  LEN state:
//   - when the slot is free, load {2'b01, ct_len(64b, zero-extended), aad_len(64b, zero-extended)};
//   - out_is_len=1 on that block.
//  Protocol errors set err, and the beat is still processed:
//   - in_bytes==0 or in_bytes>16: the beat is treated as 16 bytes;
//   - in_bytes<16 without in_last.
//  Counter overflow: counters wrap modulo 2^LEN_W and set err.
//  Reset mid-message: immediate return to IDLE; any pending output block is discarded.
//  in_valid while not in AAD/CT: ignored; in_ready=0.
// STRUCTURE
//  Shared package chacha_poly_pkg holds:
//   - BLOCK_BYTES=16;
//   - POLY_HIBIT=130'h1<<128;
//   - state encoding localparams (IDLE=0, AAD=1, CT=2, LEN=3).
//  Sub-module poly1305_byte_mask: combinational 128-bit zero-mask from in_bytes. Holds the
//   clamp-to-16 rule and the err_bytes flag.
//  Top level contains the FSM, the two length counters and the output register.
// TESTING
//  1. has_aad=1, has_ct=1; AAD 12B, CT 16B; out_ready=1 -> 3 blocks:
//     - AAD block with bytes 12..15 = 0, [128]=1;
//     - CT block;
//     - len block low64=12, high64=16, out_is_len=1; done pulses once.
//  2. has_aad=0, has_ct=1; CT 34B in beats 16,16,2 -> 3 CT blocks, then len block {64'd34, 64'd0}.
//  3. has_aad=0, has_ct=0 -> single len block {128'h0} | hibit, out_is_len=1; no data beats accepted.
//  4. out_ready held 0 for 5 cycles mid-CT -> in_ready=0, out_block stable; no beat lost or duplicated.
//  5. Beat with in_bytes=5, in_last=0 -> err=1, stays 1 until the next start; flow continues.
//  6. reset_n low during CT with out_valid=1 -> all outputs at reset values; the next start runs clean.

Source files
------------

// File: rtl/chacha_poly_pkg.sv
// Shared constants and formatter state encoding for the ChaCha20-Poly1305 MAC feeder path.
package chacha_poly_pkg;

    localparam int           BLOCK_BYTES = 16;
    localparam logic [129:0] POLY_HIBIT  = 130'h1 << 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AAD  = 2'd1,
        CT   = 2'd2,
        LEN  = 2'd3
    } fmt_state_e;

endpackage

// File: rtl/poly1305_byte_mask.sv
// Builds the zero-pad byte mask for one 16-byte beat. Out-of-range byte counts are
// clamped to a full beat and flagged so the formatter can raise its sticky error.
module poly1305_byte_mask
    import chacha_poly_pkg::*;
(
    input  logic [4:0]   in_bytes,
    output logic [127:0] byteMask,
    output logic [4:0]   effBytes,
    output logic         bytesErr
);

    always_comb begin
        bytesErr = (in_bytes == 5'd0) || (in_bytes > 5'(BLOCK_BYTES));
        effBytes = bytesErr ? 5'(BLOCK_BYTES) : in_bytes;
        byteMask = '0;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            byteMask[8*k +: 8] = (5'(k) < effBytes) ? 8'hFF : 8'h00;
        end
    end

endmodule

// File: rtl/poly1305_block_formatter.sv
// Turns AAD/CT beats into RFC 8439 Poly1305 blocks (block + 2^128) followed by the
// length block, through a one-entry output register that supports accept-and-refill.
module poly1305_block_formatter
    import chacha_poly_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         has_aad,
    input  logic         has_ct,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [4:0]   in_bytes,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [129:0] out_block,
    output logic         out_is_len,
    output logic         busy,
    output logic         done,
    output logic         err
);

    fmt_state_e         state_q, state_d;
    logic [LEN_W-1:0]   aadLen_q, aadLen_d;
    logic [LEN_W-1:0]   ctLen_q, ctLen_d;
    logic               hasCt_q, hasCt_d;
    logic               outValid_q, outValid_d;
    logic [129:0]       outBlock_q, outBlock_d;
    logic               outIsLen_q, outIsLen_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [127:0]       byteMask;
    logic [4:0]         effBytes;
    logic               bytesErr;
    logic               beatFire;
    logic               slotFree;
    logic [LEN_W:0]     lenSum;

    poly1305_byte_mask u_mask (
        .in_bytes (in_bytes),
        .byteMask (byteMask),
        .effBytes (effBytes),
        .bytesErr (bytesErr)
    );

    assign slotFree = !outValid_q || out_ready;
    assign in_ready = ((state_q == AAD) || (state_q == CT)) && slotFree;
    assign beatFire = in_valid && in_ready;

    // The carry bit of this sum is the counter-overflow indication.
    assign lenSum = ((state_q == CT) ? {1'b0, ctLen_q} : {1'b0, aadLen_q})
                  + (LEN_W+1)'(effBytes);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            aadLen_q   <= '0;
            ctLen_q    <= '0;
            hasCt_q    <= 1'b0;
            outValid_q <= 1'b0;
            outBlock_q <= '0;
            outIsLen_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            aadLen_q   <= aadLen_d;
            ctLen_q    <= ctLen_d;
            hasCt_q    <= hasCt_d;
            outValid_q <= outValid_d;
            outBlock_q <= outBlock_d;
            outIsLen_q <= outIsLen_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        aadLen_d   = aadLen_q;
        ctLen_d    = ctLen_q;
        hasCt_d    = hasCt_q;
        outValid_d = outValid_q;
        outBlock_d = outBlock_q;
        outIsLen_d = outIsLen_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
            outIsLen_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    aadLen_d = '0;
                    ctLen_d  = '0;
                    err_d    = 1'b0;
                    hasCt_d  = has_ct;
                    if (has_aad) begin
                        state_d = AAD;
                    end else if (has_ct) begin
                        state_d = CT;
                    end else begin
                        state_d = LEN;
                    end
                end
            end
            AAD, CT: begin
                if (beatFire) begin
                    outValid_d = 1'b1;
                    outIsLen_d = 1'b0;
                    outBlock_d = POLY_HIBIT | {2'b00, in_data & byteMask};
                    if (state_q == AAD) begin
                        aadLen_d = lenSum[LEN_W-1:0];
                    end else begin
                        ctLen_d = lenSum[LEN_W-1:0];
                    end
                    if (bytesErr || lenSum[LEN_W] ||
                        ((effBytes < 5'(BLOCK_BYTES)) && !in_last)) begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ((state_q == AAD) && hasCt_q) ? CT : LEN;
                    end
                end
            end
            LEN: begin
                // Once the length block sits in the slot, only its acceptance matters.
                if (outValid_q && outIsLen_q) begin
                    if (out_ready) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (slotFree) begin
                    outValid_d = 1'b1;
                    outIsLen_d = 1'b1;
                    outBlock_d = POLY_HIBIT | {2'b00, 64'(ctLen_q), 64'(aadLen_q)};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = outValid_q;
    assign out_block  = outBlock_q;
    assign out_is_len = outIsLen_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
